// File: rtl/grid_access_arbiter.sv
// Grid access arbiter: round-robin access for NREQ requesters to a shared grid memory
// supporting read, write and an atomic claim (write-if-empty) operation.
module grid_access_arbiter #(
    parameter int unsigned   NREQ  = 4,
    parameter int unsigned   AW    = 12,
    parameter int unsigned   DW    = 32,
    parameter int unsigned   CELLS = 49,
    parameter logic [DW-1:0] EMPTY = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   op,
    input  logic [AW*NREQ-1:0]  addr,
    input  logic [DW*NREQ-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [DW-1:0]       rdata,
    output logic                claim_ok,
    output logic                err,
    output logic                busy,
    output logic                mem_re,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout
);

    localparam int unsigned IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] CELLS_LIM = (AW+1)'(CELLS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_CLAIM  = 2'b10;

    logic [1:0]      r_state, w_state_nxt;
    logic [IW-1:0]   r_last, w_last_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [1:0]      r_op, w_op_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;

    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [DW-1:0]   r_rdata, w_rdata_nxt;
    logic            r_claim_ok, w_claim_ok_nxt;
    logic            r_err, w_err_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_mem_re, w_mem_re_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_din, w_mem_din_nxt;

    logic            w_any;
    logic [IW-1:0]   w_pick;
    logic [1:0]      w_sel_op;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_in_range;
    logic            w_r_in_range;

    // Round-robin search starting one past the last granted requester
    always_comb begin : p_arb
        int unsigned k;
        w_any  = 1'b0;
        w_pick = '0;
        k      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = 32'(r_last) + 32'd1 + i;
            if (k >= NREQ) k = k - NREQ;
            if (!w_any && req[IW'(k)]) begin
                w_any  = 1'b1;
                w_pick = IW'(k);
            end
        end
    end

    assign w_sel_op       = op[2*w_pick +: 2];
    assign w_sel_addr     = addr[AW*w_pick +: AW];
    assign w_sel_wdata    = wdata[DW*w_pick +: DW];
    assign w_sel_in_range = ({1'b0, w_sel_addr} < CELLS_LIM);
    assign w_r_in_range   = ({1'b0, r_addr} < CELLS_LIM);

    // Grant is the acceptance pulse of the IDLE cycle itself
    assign gnt = (r_state == S_IDLE && w_any && !reset) ? (NREQ'(1) << w_pick) : '0;

    // Next state and next registered outputs; outputs are computed on entry to each state
    always_comb begin : p_next
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_idx_nxt      = r_idx;
        w_op_nxt       = r_op;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_done_nxt     = '0;
        w_rdata_nxt    = '0;
        w_claim_ok_nxt = 1'b0;
        w_err_nxt      = 1'b0;
        w_busy_nxt     = 1'b1;
        w_mem_re_nxt   = 1'b0;
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt    = S_ISSUE;
                    w_busy_nxt     = 1'b1;
                    w_last_nxt     = w_pick;
                    w_idx_nxt      = w_pick;
                    w_op_nxt       = w_sel_op;
                    w_addr_nxt     = w_sel_addr;
                    w_wdata_nxt    = w_sel_wdata;
                    w_mem_addr_nxt = w_sel_addr;
                    w_mem_din_nxt  = (w_sel_op == OP_WRITE) ? w_sel_wdata : '0;
                    if (w_sel_in_range) begin
                        w_mem_we_nxt = (w_sel_op == OP_WRITE);
                        w_mem_re_nxt = (w_sel_op != OP_WRITE);
                    end
                end
            end
            S_ISSUE: begin
                if (!w_r_in_range) begin
                    w_state_nxt = S_RESP;
                    w_done_nxt  = NREQ'(1) << r_idx;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = EMPTY;
                end else if (r_op == OP_WRITE) begin
                    w_state_nxt = S_RESP;
                    w_done_nxt  = NREQ'(1) << r_idx;
                    w_rdata_nxt = r_wdata;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Claim's conditional write lands in RESP with no gap for another requester
                w_state_nxt = S_RESP;
                w_done_nxt  = NREQ'(1) << r_idx;
                w_rdata_nxt = mem_dout;
                if (r_op == OP_CLAIM && mem_dout == EMPTY) begin
                    w_claim_ok_nxt = 1'b1;
                    w_mem_we_nxt   = 1'b1;
                    w_mem_din_nxt  = r_wdata;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_busy_nxt     = 1'b0;
                w_mem_addr_nxt = '0;
                w_mem_din_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last     <= IW'(NREQ - 1);
            r_idx      <= '0;
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_claim_ok <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_idx      <= w_idx_nxt;
            r_op       <= w_op_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
            r_claim_ok <= w_claim_ok_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_mem_re   <= w_mem_re_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
        end
    end

    assign done     = r_done;
    assign rdata    = r_rdata;
    assign claim_ok = r_claim_ok;
    assign err      = r_err;
    assign busy     = r_busy;
    assign mem_re   = r_mem_re;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Bench for grid_access_arbiter: vector table plus multi-cycle sequences, checked
// through a response scoreboard against a behavioural grid memory.
module tb_grid_access_arbiter;

    localparam logic [31:0] EMPTY = 32'hFFFFFFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [7:0]   op;
    logic [47:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   gnt, done;
    logic [31:0]  rdata;
    logic         claim_ok, err, busy, mem_re, mem_we;
    logic [11:0]  mem_addr;
    logic [31:0]  mem_din, mem_dout;

    always #5 clk = ~clk;

    grid_access_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .claim_ok(claim_ok), .err(err),
        .busy(busy), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] rd;
        logic        ok;
        logic        er;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Response monitor: every done pops the oldest expectation
    always begin
        @(negedge clk); #1;
        if (!reset) begin
            if (gnt !== 4'b0) check("gnt_while_busy", {31'b0, busy}, 32'd0);
            if (done !== 4'b0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {28'b0, done}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("done_onehot", {28'b0, done}, 32'd1 << mon_e.idx);
                    check("rdata", rdata, mon_e.rd);
                    check("claim_ok", {31'b0, claim_ok}, {31'b0, mon_e.ok});
                    check("err", {31'b0, err}, {31'b0, mon_e.er});
                end
            end
        end
    end

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        ok;
        logic        er;
        int          lat;
        int          nre;
        int          nwe;
    } vec_t;
    vec_t vt[12];

    task automatic drive(input int idx, input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
        op[idx*2 +: 2]     = o;
        addr[idx*12 +: 12] = a;
        wdata[idx*32 +: 32] = d;
        req[idx]           = 1'b1;
    endtask

    task automatic wait_gnt_any(output logic [3:0] g, output int c);
        g = '0;
        c = -1;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (gnt !== 4'b0) begin
                g = gnt;
                c = cyc;
                return;
            end
            @(negedge clk); #1;
        end
        fail_timeout("gnt_wait");
    endtask

    task automatic wait_done(input int idx, output int c);
        c = -1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #1;
            if (done[idx]) begin
                c = cyc;
                return;
            end
        end
        fail_timeout("done_wait");
    endtask

    task automatic run_txn(input vec_t v);
        logic [3:0] g;
        int c0, c1, nre, nwe, re_c, we_c;
        nre = 0; nwe = 0; re_c = -1; we_c = -1; c1 = -1;
        sbq.push_back('{v.idx, v.rd, v.ok, v.er});
        drive(v.idx, v.op, v.a, v.d);
        wait_gnt_any(g, c0);
        check("gnt_idx", {28'b0, g}, 32'd1 << v.idx);
        @(posedge clk); #1;
        req[v.idx] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            if (mem_re) begin
                nre++;
                re_c = cyc;
                check("re_addr", {20'b0, mem_addr}, {20'b0, v.a});
            end
            if (mem_we) begin
                nwe++;
                we_c = cyc;
                check("we_addr", {20'b0, mem_addr}, {20'b0, v.a});
                check("we_din", mem_din, v.d);
            end
            if (done[v.idx]) begin
                c1 = cyc;
                break;
            end
        end
        if (c1 < 0) fail_timeout("txn_done");
        else check("latency", 32'(c1 - c0), 32'(v.lat));
        check("re_count", 32'(nre), 32'(v.nre));
        check("we_count", 32'(nwe), 32'(v.nwe));
        if (v.nre > 0) check("re_cycle", 32'(re_c - c0), 32'd1);
        if (v.nwe > 0) check("we_cycle", 32'(we_c - c0), (v.op == 2'b01) ? 32'd1 : 32'd3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] g;
        int c, last_done, nwe;
        int exp_idx;

        for (int i = 0; i < 4096; i++) mem[i] = EMPTY;
        mem_dout = '0;
        req = '0; op = '0; addr = '0; wdata = '0;

        vt[0]  = '{0, 2'b01, 12'd10,   32'd5,      32'd5,    1'b0, 1'b0, 2, 0, 1};
        vt[1]  = '{0, 2'b00, 12'd10,   32'd0,      32'd5,    1'b0, 1'b0, 3, 1, 0};
        vt[2]  = '{2, 2'b10, 12'd24,   32'd7,      EMPTY,    1'b1, 1'b0, 3, 1, 1};
        vt[3]  = '{3, 2'b00, 12'd24,   32'd0,      32'd7,    1'b0, 1'b0, 3, 1, 0};
        vt[4]  = '{1, 2'b10, 12'd24,   32'd3,      32'd7,    1'b0, 1'b0, 3, 1, 0};
        vt[5]  = '{3, 2'b00, 12'd49,   32'd0,      EMPTY,    1'b0, 1'b1, 2, 0, 0};
        vt[6]  = '{1, 2'b01, 12'd48,   32'hABCD,   32'hABCD, 1'b0, 1'b0, 2, 0, 1};
        vt[7]  = '{2, 2'b11, 12'd48,   32'd0,      32'hABCD, 1'b0, 1'b0, 3, 1, 0};
        vt[8]  = '{0, 2'b10, 12'd100,  32'd1,      EMPTY,    1'b0, 1'b1, 2, 0, 0};
        vt[9]  = '{1, 2'b01, 12'd4095, 32'd2,      EMPTY,    1'b0, 1'b1, 2, 0, 0};
        vt[10] = '{3, 2'b10, 12'd0,    32'd9,      EMPTY,    1'b1, 1'b0, 3, 1, 1};
        vt[11] = '{3, 2'b10, 12'd0,    32'd4,      32'd9,    1'b0, 1'b0, 3, 1, 0};

        // Reset with a pending request: no grant and all outputs low
        reset = 1'b1;
        req[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ctrl", {19'b0, gnt, done, claim_ok, err, busy, mem_re, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        req[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;

        foreach (vt[i]) run_txn(vt[i]);

        // All four request together right after reset: order 0,1,2,3, back to back
        do_reset();
        @(negedge clk); #1;
        drive(0, 2'b00, 12'd10, 32'd0);
        drive(1, 2'b00, 12'd24, 32'd0);
        drive(2, 2'b00, 12'd48, 32'd0);
        drive(3, 2'b00, 12'd0,  32'd0);
        sbq.push_back('{0, 32'd5, 1'b0, 1'b0});
        sbq.push_back('{1, 32'd7, 1'b0, 1'b0});
        sbq.push_back('{2, 32'hABCD, 1'b0, 1'b0});
        sbq.push_back('{3, 32'd9, 1'b0, 1'b0});
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt_any(g, c);
            check("rr_order", {28'b0, g}, 32'd1 << k);
            if (k > 0) check("rr_gap", 32'(c - last_done), 32'd1);
            @(posedge clk); #1;
            req[k] = 1'b0;
            wait_done(k, last_done);
        end

        // Reset while a claim is in CAPTURE: aborted, no write, cell stays free
        @(negedge clk); #1;
        drive(1, 2'b10, 12'd30, 32'h55);
        wait_gnt_any(g, c);
        check("abort_gnt", {28'b0, g}, 32'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk); #1;
        check("abort_issue_re", {31'b0, mem_re}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ctrl", {19'b0, gnt, done, claim_ok, err, busy, mem_re, mem_we}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_mem_addr", {20'b0, mem_addr}, 32'd0);
        check("abort_mem_din", mem_din, 32'd0);
        reset = 1'b0;
        nwe = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            if (mem_we) nwe++;
        end
        check("abort_no_write", 32'(nwe), 32'd0);
        check("abort_cell", mem[30], EMPTY);
        run_txn('{3, 2'b00, 12'd30, 32'd0, EMPTY, 1'b0, 1'b0, 3, 1, 0});

        // Two requesters held high: strict alternation, re-grant of a held request
        drive(0, 2'b00, 12'd10, 32'd0);
        drive(1, 2'b00, 12'd10, 32'd0);
        for (int k = 0; k < 4; k++) sbq.push_back('{k % 2, 32'd5, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            exp_idx = k % 2;
            wait_gnt_any(g, c);
            check("fair_order", {28'b0, g}, 32'd1 << exp_idx);
            if (k > 0) check("fair_gap", 32'(c - last_done), 32'd1);
            @(posedge clk); #1;
            if (k >= 2) req[exp_idx] = 1'b0;
            wait_done(exp_idx, last_done);
        end

        // A lone request still high after done is served again
        drive(2, 2'b00, 12'd24, 32'd0);
        sbq.push_back('{2, 32'd7, 1'b0, 1'b0});
        sbq.push_back('{2, 32'd7, 1'b0, 1'b0});
        wait_gnt_any(g, c);
        check("hold_gnt1", {28'b0, g}, 32'd4);
        wait_done(2, last_done);
        wait_gnt_any(g, c);
        check("hold_gnt2", {28'b0, g}, 32'd4);
        check("hold_gap", 32'(c - last_done), 32'd1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_done(2, last_done);

        repeat (4) @(negedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_access_arbiter.md
GRID_ACCESS_ARBITER -- requirements
Module: grid_access_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NREQ, 4, number of requesters.
- AW, 12, grid address width.
- DW, 32, data width.
- CELLS, 49, valid grid cells (n*n).
- EMPTY, 32'hFFFFFFFF, free-cell marker.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  request per requester; held high until gnt.
- op  in  2*NREQ  per-requester op: 00 read, 01 write, 10 claim, 11 treated as read.
- addr  in  AW*NREQ  per-requester cell address.
- wdata  in  DW*NREQ  per-requester write/claim data.
- gnt  out  NREQ  one-hot, 1-cycle pulse when a request is accepted.
- done  out  NREQ  one-hot, 1-cycle pulse at completion, to the granted requester.
- rdata  out  DW  result data, valid with done.
- claim_ok  out  1  claim succeeded, valid with done.
- err  out  1  address out of range, valid with done.
- busy  out  1  high in every state except IDLE.
- mem_re  out  1  grid read strobe.
- mem_we  out  1  grid write strobe.
- mem_addr  out  AW  grid address.
- mem_din  out  DW  grid write data.
- mem_dout  in  DW  grid read data; valid the cycle after mem_re and held until the next read.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and RESP.
REQ-004 In IDLE with any req bit high, the arbiter SHALL grant one requester round-robin:
- search starts at last_grant+1, modulo NREQ;
- gnt pulses that cycle;
- op, addr and wdata of the granted requester are latched;
- the FSM goes to ISSUE.
REQ-005 req SHALL be sampled only in IDLE; requests arriving during busy wait without loss.
REQ-006 In ISSUE, with latched addr < CELLS:
- read and claim assert mem_re and go to CAPTURE;
- write asserts mem_we with mem_din=wdata and goes to RESP.
REQ-007 In ISSUE with latched addr >= CELLS, there SHALL be no memory strobe, err is set and the FSM goes to RESP.
REQ-008 CAPTURE SHALL register mem_dout into an internal data register and go to RESP.
REQ-009 In RESP, for a claim whose captured value equals EMPTY:
- mem_we=1, mem_addr=latched addr, mem_din=wdata;
- claim_ok=1.
A claim whose captured value is not EMPTY SHALL give claim_ok=0 and no write.
REQ-010 In RESP, done SHALL pulse for the granted requester, then the FSM returns to IDLE.
- rdata = captured value for read/claim, wdata for write, EMPTY on err.
REQ-011 Latency, with gnt in cycle T: read/claim done at T+3; write and err done at T+2.
REQ-012 Nothing else (including another requester) SHALL be able to write between a claim's read and its conditional write, so the claim is atomic.
REQ-013 mem_addr SHALL hold the latched addr from ISSUE through RESP; strobes are 0 in all other states.
REQ-014 last_grant SHALL update only on a grant; the same requester cannot be granted twice in a row while another requester is waiting.
REQ-015 If req is still high in the IDLE cycle after done, it SHALL be treated as a new request.

Reset
REQ-016 On reset, regardless of state, the following SHALL be 0: gnt, done, mem_re, mem_we, claim_ok, err, busy, rdata, mem_addr, mem_din.
REQ-017 On reset, the FSM SHALL go to IDLE and last_grant to NREQ-1, so requester 0 has first priority.
REQ-018 Reset mid-operation SHALL abort the operation: no done and no pending write is issued afterwards.

Verification
REQ-019 Read: req[0] read, addr 10, memory holds 5 -> gnt[0] at T, mem_re at T+1, done[0] at T+3 with rdata=5, claim_ok=0.
REQ-020 Claim on free cell: req[2] claim, addr 24, cell=EMPTY, wdata=7 -> mem_we at T+3 with addr 24, din 7; claim_ok=1.
- A following read of addr 24 returns 7.
REQ-021 Claim on occupied cell: cell 24 holds 7, req[1] claim wdata 3 -> claim_ok=0, rdata=7, no mem_we.
REQ-022 Simultaneous req=4'b1111 after reset -> grant order 0,1,2,3.
- Each gnt follows the previous done by one cycle.
- No gnt while busy.
REQ-023 Out of range: addr 49 -> err=1, rdata=EMPTY, done at T+2, no mem_re/mem_we.
REQ-024 Reset asserted in CAPTURE of a claim -> next cycle IDLE, all outputs 0, cell unchanged.
